// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK
    } state_t;

    // Instruction word: [31:28] opcode, [27:23] rd, [22:18] ra, [17:13] rb, [12:0] offset
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BGT = 4'hB;
    localparam logic [3:0] OP_BGE = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;

    // Compare selects driven into cmp
    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_GT = 2'd1;
    localparam logic [1:0] CMP_GE = 2'd2;

    localparam int DEF_RESET_PC          = 0;
    localparam int DEF_EXCEPTION_ADDRESS = 69;

endpackage

// File: rtl/alu.sv
// Integer ALU for register-register operations.
// Latency: combinational.
// Backpressure: none.
module alu #(
    parameter int DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    input  logic [2:0]           op_i,
    output logic [DATAWIDTH-1:0] y_o
);
    // Operation select follows the low opcode bits
    always_comb begin
        y_o = '0;
        case (op_i)
            3'd0: y_o = a_i + b_i;
            3'd1: y_o = a_i - b_i;
            3'd2: y_o = a_i & b_i;
            3'd3: y_o = a_i | b_i;
            3'd4: y_o = a_i ^ b_i;
            3'd5: y_o = a_i << b_i[4:0];
            3'd6: y_o = a_i >> b_i[4:0];
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/cmp.sv
// Signed comparator resolving branch conditions.
// Latency: combinational.
// Backpressure: none.
module cmp
    import core_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    input  logic [1:0]           op_i,
    output logic                 taken_o
);
    // Branch condition; GT/GE compare as two's complement
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            CMP_EQ:  taken_o = (a_i == b_i);
            CMP_GT:  taken_o = ($signed(a_i) >  $signed(b_i));
            CMP_GE:  taken_o = ($signed(a_i) >= $signed(b_i));
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/core_ctrl.sv
// FETCH/EXECUTE/MEM/WRITEBACK sequencer with memory handshakes and phase strobes.
// Latency: 3 cycles ALU/branch/JMP, 4 cycles LW/SW, 2 cycles illegal, with zero-wait memory.
// Backpressure: holds FETCH until imem_ready_i and MEM until dmem_ready_i; one access at a time.
module core_ctrl
    import core_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic imem_ready_i,
    input  logic dmem_ready_i,
    input  logic illegal_i,
    input  logic is_mem_i,
    input  logic is_store_i,
    output logic imem_req_o,
    output logic dmem_req_o,
    output logic dmem_we_o,
    output logic fetch_done_o,
    output logic exec_o,
    output logic mem_done_o,
    output logic retire_o,
    output logic exception_o
);
    state_t state_q, state_d;

    // Outputs decode straight from the state register so they never glitch on inputs
    assign imem_req_o   = (state_q == ST_FETCH);
    assign exec_o       = (state_q == ST_EXECUTE);
    assign dmem_req_o   = (state_q == ST_MEM);
    assign retire_o     = (state_q == ST_WRITEBACK);
    assign dmem_we_o    = dmem_req_o & is_store_i;
    assign fetch_done_o = imem_req_o & imem_ready_i;
    assign mem_done_o   = dmem_req_o & dmem_ready_i;
    assign exception_o  = exec_o & illegal_i;

    // Next-state selection; requests hold until their ready arrives
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (imem_ready_i) state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (illegal_i)     state_d = ST_FETCH;
                else if (is_mem_i) state_d = ST_MEM;
                else               state_d = ST_WRITEBACK;
            end
            ST_MEM:       if (dmem_ready_i) state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end
endmodule

// File: rtl/decoder.sv
// Splits an instruction word into fields and instruction-class flags.
// Latency: combinational.
// Backpressure: none.
module decoder
    import core_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        is_alu_o,
    output logic        is_lw_o,
    output logic        is_sw_o,
    output logic        is_branch_o,
    output logic        is_jmp_o,
    output logic        illegal_o,
    output logic [2:0]  alu_op_o,
    output logic [1:0]  cmp_op_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  ra_o,
    output logic [4:0]  rb_o,
    output logic [12:0] offset_o
);
    logic [3:0] opcode;

    assign opcode   = instr_i[31:28];
    assign rd_o     = instr_i[27:23];
    assign ra_o     = instr_i[22:18];
    assign rb_o     = instr_i[17:13];
    assign offset_o = instr_i[12:0];
    assign alu_op_o = opcode[2:0];

    // Classify the opcode; anything unassigned is illegal
    always_comb begin
        is_alu_o    = 1'b0;
        is_lw_o     = 1'b0;
        is_sw_o     = 1'b0;
        is_branch_o = 1'b0;
        is_jmp_o    = 1'b0;
        illegal_o   = 1'b0;
        cmp_op_o    = CMP_EQ;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR: is_alu_o = 1'b1;
            OP_LW:  is_lw_o = 1'b1;
            OP_SW:  is_sw_o = 1'b1;
            OP_BEQ: begin is_branch_o = 1'b1; cmp_op_o = CMP_EQ; end
            OP_BGT: begin is_branch_o = 1'b1; cmp_op_o = CMP_GT; end
            OP_BGE: begin is_branch_o = 1'b1; cmp_op_o = CMP_GE; end
            OP_JMP: is_jmp_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/regbank.sv
// Register file: two combinational read ports, one synchronous write port.
// Latency: reads combinational, write visible the cycle after we_i.
// Backpressure: none; all registers clear on reset.
module regbank #(
    parameter int DATAWIDTH = 32,
    parameter int NUMREGS   = 32,
    parameter int AW        = $clog2(NUMREGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_a_i,
    input  logic [AW-1:0]        raddr_b_i,
    output logic [DATAWIDTH-1:0] rdata_a_o,
    output logic [DATAWIDTH-1:0] rdata_b_o
);
    logic [DATAWIDTH-1:0] regs_q [NUMREGS];
    logic [DATAWIDTH-1:0] regs_d [NUMREGS];

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

    // Single write port update
    always_comb begin
        regs_d = regs_q;
        if (we_i) regs_d[waddr_i] = wdata_i;
    end

    // Register storage with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUMREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end
endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core top: ir/operand/result/pc registers around decoder, alu, cmp, regbank.
// Latency: 3 cycles ALU/branch/JMP, 4 cycles LW/SW, 2 cycles illegal, plus memory wait cycles.
// Backpressure: stalls on imem_ready_i / dmem_ready_i; request, address and data held stable meanwhile.
module multicycle_core
    import core_pkg::*;
#(
    parameter int DATAWIDTH         = 32,
    parameter int NUMREGS           = 32,
    parameter int RESET_PC          = DEF_RESET_PC,
    parameter int EXCEPTION_ADDRESS = DEF_EXCEPTION_ADDRESS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic                 imem_ready_i,
    input  logic [31:0]          imem_rdata_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [DATAWIDTH-1:0] dmem_addr_o,
    output logic [DATAWIDTH-1:0] dmem_wdata_o,
    input  logic                 dmem_ready_i,
    input  logic [DATAWIDTH-1:0] dmem_rdata_i,
    output logic [DATAWIDTH-1:0] pc_o,
    output logic                 retire_o,
    output logic                 exception_o
);
    localparam int RF_AW = $clog2(NUMREGS);

    logic [31:0]          ir_q, ir_d;
    logic [DATAWIDTH-1:0] pc_q, pc_d, addr_q, addr_d, wdata_q, wdata_d, res_q, res_d;
    logic                 take_q, take_d;

    logic                 is_alu, is_lw, is_sw, is_branch, is_jmp, illegal;
    logic [2:0]           alu_op;
    logic [1:0]           cmp_op;
    logic [4:0]           rd, ra, rb;
    logic [12:0]          offset;
    logic [DATAWIDTH-1:0] off_ext, ra_val, rb_val, alu_y;
    logic                 cmp_taken;
    logic                 fetch_done, exec_en, mem_done, rf_we;

    assign off_ext      = {{(DATAWIDTH-13){offset[12]}}, offset};
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign rf_we        = retire_o & (is_alu | is_lw);

    core_ctrl u_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .illegal_i    (illegal),
        .is_mem_i     (is_lw | is_sw),
        .is_store_i   (is_sw),
        .imem_req_o   (imem_req_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .fetch_done_o (fetch_done),
        .exec_o       (exec_en),
        .mem_done_o   (mem_done),
        .retire_o     (retire_o),
        .exception_o  (exception_o)
    );

    decoder u_dec (
        .instr_i     (ir_q),
        .is_alu_o    (is_alu),
        .is_lw_o     (is_lw),
        .is_sw_o     (is_sw),
        .is_branch_o (is_branch),
        .is_jmp_o    (is_jmp),
        .illegal_o   (illegal),
        .alu_op_o    (alu_op),
        .cmp_op_o    (cmp_op),
        .rd_o        (rd),
        .ra_o        (ra),
        .rb_o        (rb),
        .offset_o    (offset)
    );

    regbank #(.DATAWIDTH(DATAWIDTH), .NUMREGS(NUMREGS)) u_rf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (rf_we),
        .waddr_i   (is_lw ? rb[RF_AW-1:0] : rd[RF_AW-1:0]),
        .wdata_i   (res_q),
        .raddr_a_i (ra[RF_AW-1:0]),
        .raddr_b_i (rb[RF_AW-1:0]),
        .rdata_a_o (ra_val),
        .rdata_b_o (rb_val)
    );

    alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .a_i  (ra_val),
        .b_i  (rb_val),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    cmp #(.DATAWIDTH(DATAWIDTH)) u_cmp (
        .a_i     (ra_val),
        .b_i     (rb_val),
        .op_i    (cmp_op),
        .taken_o (cmp_taken)
    );

    // Datapath register updates per phase; pc moves only on trap or retire
    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        res_d   = res_q;
        take_d  = take_q;
        if (fetch_done) ir_d = imem_rdata_i;
        if (exec_en) begin
            addr_d  = ra_val + off_ext;
            wdata_d = rb_val;
            res_d   = alu_y;
            take_d  = is_jmp | (is_branch & cmp_taken);
        end
        if (mem_done && !is_sw) res_d = dmem_rdata_i;
        if (exception_o)   pc_d = DATAWIDTH'(EXCEPTION_ADDRESS);
        else if (retire_o) pc_d = take_q ? pc_q + off_ext : pc_q + DATAWIDTH'(4);
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_q    <= '0;
            pc_q    <= DATAWIDTH'(RESET_PC);
            addr_q  <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            take_q  <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            res_q   <= res_d;
            take_q  <= take_d;
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core with behavioural instruction/data memories.
// Latency: n/a.
// Backpressure: data memory inserts a programmable number of wait cycles per access.
module tb_multicycle_core;
    localparam logic [3:0] T_ADD = 4'h0, T_LW = 4'h8, T_SW = 4'h9, T_BEQ = 4'hA,
                           T_BGT = 4'hB, T_BGE = 4'hC, T_JMP = 4'hD, T_BAD = 4'hF;

    logic        clk_i, rst_i;
    logic        imem_req_o, imem_ready_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        dmem_req_o, dmem_we_o, dmem_ready_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [31:0] pc_o;
    logic        retire_o, exception_o;

    logic [31:0] imem [64];
    logic [31:0] dmem_init [64];
    int          dmem_wait;
    int          wcnt;
    int          store_cnt;
    int          both_hi;
    int          n_checks, n_err;

    multicycle_core dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i),
        .pc_o         (pc_o),
        .retire_o     (retire_o),
        .exception_o  (exception_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign imem_rdata_i = imem[imem_addr_o[7:2]];
    assign dmem_rdata_i = dmem_init[dmem_addr_o[7:2]];
    assign dmem_ready_i = dmem_req_o && (wcnt >= dmem_wait);

    // Data memory wait counter and store observer
    always @(posedge clk_i) begin
        if (!dmem_req_o || dmem_ready_i) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
        if (dmem_req_o && dmem_ready_i && dmem_we_o) store_cnt <= store_cnt + 1;
    end

    always @(negedge clk_i) if (retire_o && exception_o) both_hi <= both_hi + 1;

    function automatic logic [31:0] enc(logic [3:0] op, int rd, int ra, int rb, int off);
        logic [4:0]  f_rd, f_ra, f_rb;
        logic [12:0] f_off;
        f_rd = rd[4:0]; f_ra = ra[4:0]; f_rb = rb[4:0]; f_off = off[12:0];
        return {op, f_rd, f_ra, f_rb, f_off};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Starts at the first (FETCH) cycle of an instruction; ends at the next one
    task automatic run_instr(output int n, output bit exc, output bit ret);
        n = 1;
        while (!retire_o && !exception_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        exc = exception_o;
        ret = retire_o;
        @(negedge clk_i);
    endtask

    task automatic exec_chk(input string tag, input int exp_n);
        int n; bit e, r;
        run_instr(n, e, r);
        check(tag, n, exp_n);
    endtask

    initial begin
        int n, stable, saved;
        bit e, r;
        n_checks = 0; n_err = 0; store_cnt = 0; both_hi = 0; wcnt = 0;
        rst_i = 1'b1; imem_ready_i = 1'b1; dmem_wait = 0;
        for (int i = 0; i < 64; i++) begin imem[i] = '0; dmem_init[i] = '0; end
        dmem_init[0] = 32'd5;
        dmem_init[1] = 32'd7;
        dmem_init[3] = 32'hDEAD_BEEF;
        dmem_init[4] = 32'h10;

        // Program 1: loads, add, store, delayed load
        imem[0] = enc(T_LW, 0, 0, 1, 0);
        imem[1] = enc(T_LW, 0, 0, 2, 4);
        imem[2] = enc(T_ADD, 3, 1, 2, 0);
        imem[3] = enc(T_SW, 0, 0, 3, 'h20);
        imem[4] = enc(T_LW, 0, 0, 4, 16);
        imem[5] = enc(T_LW, 0, 4, 5, -4);
        imem[6] = enc(T_SW, 0, 0, 5, 'h24);
        do_reset();
        check("rst_pc", pc_o, 0);
        check("rst_retire", retire_o, 0);
        check("rst_exception", exception_o, 0);
        check("rst_dmem_req", dmem_req_o, 0);
        check("rst_dmem_we", dmem_we_o, 0);
        check("rst_imem_req", imem_req_o, 1);
        check("rst_imem_addr", imem_addr_o, 0);
        exec_chk("lw_r1_lat", 4);
        exec_chk("lw_r2_lat", 4);
        check("add_fetch_addr", imem_addr_o, 8);
        exec_chk("add_lat", 3);
        check("add_next_pc", pc_o, 'h0C);
        repeat (2) @(negedge clk_i);
        check("sw_req", dmem_req_o, 1);
        check("sw_we", dmem_we_o, 1);
        check("sw_addr", dmem_addr_o, 'h20);
        check("sw_r3_value", dmem_wdata_o, 12);
        run_instr(n, e, r);
        check("sw_lat", n + 2, 4);
        exec_chk("lw_r4_lat", 4);
        dmem_wait = 3;
        @(negedge clk_i);
        stable = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (dmem_req_o && !dmem_we_o && dmem_addr_o == 32'h0C) stable++;
            if (k < 3) check("lw_slow_no_early_retire", retire_o, 0);
        end
        check("lw_slow_addr_stable", stable, 4);
        @(negedge clk_i);
        check("lw_slow_retire_c7", retire_o, 1);
        @(negedge clk_i);
        dmem_wait = 0;
        repeat (2) @(negedge clk_i);
        check("lw_slow_loaded", dmem_wdata_o, 32'hDEAD_BEEF);
        run_instr(n, e, r);

        // Program 2: BEQ at 0x20, taken then not taken, plus BGT/BGE
        imem[1] = enc(T_JMP, 0, 0, 0, 'h1C);
        imem[8] = enc(T_BEQ, 0, 0, 0, -8);
        do_reset();
        exec_chk("lw_lat2", 4);
        exec_chk("jmp_lat", 3);
        check("beq_fetch", imem_addr_o, 'h20);
        exec_chk("beq_lat", 3);
        check("beq_taken_next", imem_addr_o, 'h18);
        imem[8]  = enc(T_BEQ, 0, 0, 1, -8);
        imem[9]  = enc(T_BGT, 0, 1, 0, 8);
        imem[11] = enc(T_BGE, 0, 0, 1, 8);
        do_reset();
        exec_chk("lw_lat3", 4);
        exec_chk("jmp_lat2", 3);
        exec_chk("beq_nt_lat", 3);
        check("beq_not_taken_next", imem_addr_o, 'h24);
        exec_chk("bgt_lat", 3);
        check("bgt_taken_next", imem_addr_o, 'h2C);
        exec_chk("bge_lat", 3);
        check("bge_not_taken_next", imem_addr_o, 'h30);

        // Program 3: illegal instruction at 0x40 targeting r1
        imem[1]  = enc(T_JMP, 0, 0, 0, 'h3C);
        imem[16] = enc(T_BAD, 1, 0, 0, 0);
        imem[17] = enc(T_SW, 0, 0, 1, 'h28);
        do_reset();
        exec_chk("lw_lat4", 4);
        exec_chk("jmp_lat3", 3);
        check("ill_fetch", imem_addr_o, 'h40);
        run_instr(n, e, r);
        check("ill_lat", n, 2);
        check("ill_exception", e, 1);
        check("ill_no_retire", r, 0);
        check("ill_pc", pc_o, 69);
        check("ill_fetch_addr", imem_addr_o, 69);
        repeat (2) @(negedge clk_i);
        check("ill_no_reg_write", dmem_wdata_o, 5);
        run_instr(n, e, r);

        // Program 4: reset while a store waits for dmem
        imem[1] = enc(T_SW, 0, 0, 1, 'h30);
        do_reset();
        exec_chk("lw_lat5", 4);
        dmem_wait = 10;
        repeat (2) @(negedge clk_i);
        check("sw_wait_req", dmem_req_o, 1);
        @(negedge clk_i);
        saved = store_cnt;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_dmem_req", dmem_req_o, 0);
        check("rst_mid_pc", pc_o, 0);
        check("rst_mid_imem_req", imem_req_o, 1);
        rst_i = 1'b0;
        dmem_wait = 0;
        check("rst_mid_fetch_addr", imem_addr_o, 0);
        exec_chk("rst_mid_lw_lat", 4);
        check("rst_mid_store_dropped", store_cnt, saved);

        // Program 5: JMP 0 self-loop
        imem[0] = enc(T_JMP, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            exec_chk("jmp_loop_lat", 3);
            check("jmp_loop_pc", pc_o, 0);
        end

        check("never_retire_and_exception", both_hi, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle processor top. It executes the existing 4-bit-opcode ISA (ALU ops, LW, SW, BEQ, BGT, BGE, JMP) through a FETCH/EXECUTE/MEM/WRITEBACK state machine. Instruction and data memories sit outside the core on request/ready handshakes, so slow or shared memories stall the core instead of breaking it. The core reuses the existing decoder, alu, cmp and regbank blocks, and adds retire and exception observability.

## Interface
- DATAWIDTH, 32, datapath and memory word width
- NUMREGS, 32, register count passed to regbank
- RESET_PC, 0, PC value loaded on reset
- EXCEPTION_ADDRESS, 69, PC loaded on an illegal instruction
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous and active-high
- imem_req_o  out  1  instruction fetch request
- imem_addr_o  out  DATAWIDTH  fetch address (current PC)
- imem_ready_i  in  1  fetch complete; imem_rdata_i valid this cycle
- imem_rdata_i  in  32  instruction word
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  1 = store (SW), 0 = load (LW)
- dmem_addr_o  out  DATAWIDTH  ra + sign-extended offset
- dmem_wdata_o  out  DATAWIDTH  contents of rb (stores)
- dmem_ready_i  in  1  access complete; dmem_rdata_i valid this cycle for loads
- dmem_rdata_i  in  DATAWIDTH  load data
- pc_o  out  DATAWIDTH  architectural PC
- retire_o  out  1  one-cycle pulse when an instruction completes
- exception_o  out  1  one-cycle pulse when an illegal instruction is trapped

## Operation
- States: FETCH, EXECUTE, MEM, WRITEBACK.
- FETCH
  - imem_req_o = 1 and imem_addr_o = pc.
  - On imem_ready_i: latch the instruction into ir and go to EXECUTE. Otherwise stay in FETCH.
- EXECUTE
  - Decode ir, read ra/rb, compute the ALU result and compare result, latch operands and result.
  - Illegal instruction: pc ← EXCEPTION_ADDRESS, exception_o = 1, go to FETCH. No register write, no retire.
  - LW/SW: go to MEM.
  - Everything else: go to WRITEBACK.
- MEM
  - dmem_req_o = 1. Address and wdata come from latched values.
  - On dmem_ready_i: a load latches dmem_rdata_i. Go to WRITEBACK.
- WRITEBACK
  - Register write: ALU ops write rd ← ALU result; LW writes rb ← load data.
  - No register write for SW, BEQ, BGT, BGE or JMP.
  - Next PC:
    - taken branch or JMP: pc ← pc + sext(offset), where pc is the address of this instruction
    - otherwise: pc ← pc + 4
  - retire_o = 1. Go to FETCH.
- Width rules:
  - offset is 13 bits, sign-extended to DATAWIDTH.
  - PC and address arithmetic are modulo 2^DATAWIDTH; wrap-around is silent.
- Handshake rules:
  - A request is held, with stable address and data, until its ready is seen.
  - ready while req = 0 is ignored.
  - Only one outstanding access at a time.
- Reset mid-operation (any state): next cycle state = FETCH, pc = RESET_PC. Pending requests are dropped with no register write. regbank contents follow regbank's own reset.

## Timing
- Reset values: state FETCH, pc_o = RESET_PC, retire_o = 0, exception_o = 0, dmem_req_o = 0, dmem_we_o = 0. imem_req_o = 1 from the first cycle after reset.
- Latency with zero-wait memory (ready asserted the same cycle as req):
  - ALU/branch/JMP: 3 cycles
  - LW/SW: 4 cycles
  - illegal instruction: 2 cycles
- Each ready cycle held low adds one cycle.
- pc_o changes only in the cycle after WRITEBACK or the exception cycle.
- retire_o and exception_o are never high together.

## Structure
- Shared package core_pkg holds:
  - state enum state_t
  - opcode constants (migrated from the opcode defines)
  - RESET_PC and EXCEPTION_ADDRESS defaults
- Sub-module core_ctrl: the FSM and the handshake and output decode.
- multicycle_core instantiates core_ctrl, decoder, alu, cmp and regbank, plus the ir, operand, result and pc registers.

## Test plan
- Reset, then zero-wait ALU add r3 ← r1 + r2 with r1 = 5, r2 = 7:
  - imem_addr_o = 0
  - r3 = 12, retire_o in cycle 3, pc_o = 4.
- LW with r1 = 0x10, offset −4, dmem_ready_i delayed 3 cycles:
  - dmem_addr_o = 0x0C held stable for 4 cycles
  - rb written, retire_o in cycle 7.
- BEQ with equal operands and offset −8 at pc 0x20: next imem_addr_o = 0x18. With unequal operands: 0x24.
- Illegal opcode at pc 0x40:
  - exception_o pulses, no retire and no register write
  - next fetch at 69.
- rst_i asserted during a MEM wait on SW:
  - dmem_req_o drops the next cycle, the store never completes
  - fetch restarts at RESET_PC.
- JMP with offset 0 (self-loop) run for 10 iterations: pc_o is constant and retire_o pulses every 3 cycles.
